// File: rtl/mipi_csi_rx_packet_decoder.sv
// -----------------------------------------------------------------------------
// mipi_csi_rx_packet_decoder
//
// CSI-2 low-level packet decoder placed between the lane aligner and the RAW
// depacker. Each HS burst starts with a sync word, which is stripped. The
// decoder then parses the 32-bit packet header (DI, WC_L, WC_H, ECC) and
// forwards exactly WC payload bytes with per-byte keep and a last flag. Short
// packets are reported with a pulse, virtual channels can be filtered, and a
// drop of data_valid_i aborts the packet.
//
// Optional feature macro: MIPI_CSI_RX_ECC_CHECK_EN
//   defined   : header ECC is checked; a mismatch pulses ecc_error_o and the
//               packet is discarded (no correction).
//   undefined : the ECC byte is ignored and ecc_error_o stays 0.
//
// Parameters
//   LANES            byte lanes (1, 2 or 4); data width is 8*LANES
// Ports
//   clk_i            byte clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   data_valid_i     burst valid from the aligner
//   data_i           aligned bytes, lane0 in [7:0] is the earliest byte
//   vc_mask_i        bit n accepts virtual channel n
//   output_valid_o   payload word valid
//   data_o           payload bytes, same lane order as data_i
//   keep_o           per-byte valid (partial only on the last word)
//   last_o           final payload word of the packet
//   packet_type_o    header data type DI[5:0]
//   packet_vc_o      header virtual channel DI[7:6]
//   packet_length_o  header word count / short-packet data field
//   short_valid_o    pulse for an accepted short packet
//   ecc_error_o      pulse on header ECC mismatch
// -----------------------------------------------------------------------------
module mipi_csi_rx_packet_decoder #(
  parameter int LANES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 data_valid_i,
  input  logic [8*LANES-1:0]   data_i,
  input  logic [3:0]           vc_mask_i,
  output logic                 output_valid_o,
  output logic [8*LANES-1:0]   data_o,
  output logic [LANES-1:0]     keep_o,
  output logic                 last_o,
  output logic [5:0]           packet_type_o,
  output logic [1:0]           packet_vc_o,
  output logic [15:0]          packet_length_o,
  output logic                 short_valid_o,
  output logic                 ecc_error_o
);

  localparam int          W        = 8 * LANES;
  localparam logic [1:0]  HDR_LAST = 2'(4 / LANES - 1);
  localparam logic [15:0] LANES16  = 16'(LANES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    PAYLOAD  = 2'd2,
    WAIT_END = 2'd3
  } state_e;

  // CSI-2 header ECC: each parity bit covers a fixed subset of the 24 data bits
  function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [31:0]      hdr_q, hdr_d;
  logic [15:0]      rem_q, rem_d;
  logic             output_valid_q, output_valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [LANES-1:0] keep_q, keep_d;
  logic             last_q, last_d;
  logic [5:0]       type_q, type_d;
  logic [1:0]       vc_q, vc_d;
  logic [15:0]      len_q, len_d;
  logic             short_q, short_d;
  logic             ecc_err_q, ecc_err_d;

  // Header bytes shift in from the top so DI ends up in [7:0] after the last word
  logic [31+W:0]    hdr_cat_s;
  logic [31:0]      hdr_new_s;
  logic             ecc_bad_s;
  logic             unused_ok_s;

  assign hdr_cat_s = {data_i, hdr_q};
  assign hdr_new_s = hdr_cat_s[31+W:W];
`ifdef MIPI_CSI_RX_ECC_CHECK_EN
  assign ecc_bad_s = (hdr_ecc(hdr_new_s[23:0]) != hdr_new_s[29:24]);
`else
  assign ecc_bad_s = 1'b0;
`endif
  assign unused_ok_s = ^{hdr_cat_s[W-1:0], hdr_new_s[31:24]};

  // Next-state and next-output logic for the decoder FSM
  always_comb begin
    state_d        = state_q;
    hdr_cnt_d      = hdr_cnt_q;
    hdr_d          = hdr_q;
    rem_d          = rem_q;
    output_valid_d = 1'b0;
    data_d         = data_q;
    keep_d         = '0;
    last_d         = 1'b0;
    type_d         = type_q;
    vc_d           = vc_q;
    len_d          = len_q;
    short_d        = 1'b0;
    ecc_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_valid_i) begin
          if (data_i == {LANES{8'hB8}}) begin
            state_d   = HEADER;
            hdr_cnt_d = 2'd0;
          end else begin
            state_d = WAIT_END;
          end
        end else begin
          state_d = IDLE;
        end
      end

      HEADER: begin
        if (!data_valid_i) begin
          state_d = IDLE;
        end else begin
          hdr_d     = hdr_new_s;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == HDR_LAST) begin
            type_d = hdr_new_s[5:0];
            vc_d   = hdr_new_s[7:6];
            len_d  = hdr_new_s[23:8];
            rem_d  = hdr_new_s[23:8];
            if (ecc_bad_s) begin
              ecc_err_d = 1'b1;
              state_d   = WAIT_END;
            end else if (hdr_new_s[5:0] <= 6'h0F) begin
              short_d = vc_mask_i[hdr_new_s[7:6]];
              state_d = WAIT_END;
            end else if (hdr_new_s[23:8] == 16'd0) begin
              state_d = WAIT_END;
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            state_d = HEADER;
          end
        end
      end

      PAYLOAD: begin
        if (!data_valid_i) begin
          state_d = IDLE;
        end else begin
          // Filtered channels still consume bytes, they just never show up
          output_valid_d = vc_mask_i[vc_q];
          data_d         = data_i;
          // rem > LANES on non-final words, so this yields all ones there
          for (int i = 0; i < LANES; i++) begin
            keep_d[i] = vc_mask_i[vc_q] & (rem_q > 16'(i));
          end
          if (rem_q <= LANES16) begin
            last_d  = vc_mask_i[vc_q];
            rem_d   = 16'd0;
            state_d = WAIT_END;
          end else begin
            rem_d   = rem_q - LANES16;
            state_d = PAYLOAD;
          end
        end
      end

      WAIT_END: begin
        if (!data_valid_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_END;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      hdr_cnt_q      <= 2'd0;
      hdr_q          <= 32'd0;
      rem_q          <= 16'd0;
      output_valid_q <= 1'b0;
      data_q         <= '0;
      keep_q         <= '0;
      last_q         <= 1'b0;
      type_q         <= 6'd0;
      vc_q           <= 2'd0;
      len_q          <= 16'd0;
      short_q        <= 1'b0;
      ecc_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_cnt_q      <= hdr_cnt_d;
      hdr_q          <= hdr_d;
      rem_q          <= rem_d;
      output_valid_q <= output_valid_d;
      data_q         <= data_d;
      keep_q         <= keep_d;
      last_q         <= last_d;
      type_q         <= type_d;
      vc_q           <= vc_d;
      len_q          <= len_d;
      short_q        <= short_d;
      ecc_err_q      <= ecc_err_d;
    end
  end

  assign output_valid_o  = output_valid_q;
  assign data_o          = data_q;
  assign keep_o          = keep_q;
  assign last_o          = last_q;
  assign packet_type_o   = type_q;
  assign packet_vc_o     = vc_q;
  assign packet_length_o = len_q;
  assign short_valid_o   = short_q;
  assign ecc_error_o     = ecc_err_q;

endmodule

// File: doc/mipi_csi_rx_packet_decoder.md
# mipi_csi_rx_packet_decoder

Parametrised MIPI CSI-2 low-level packet decoder for 1, 2 or 4 lanes. It sits after the lane aligner and before the RAW depacker. Per burst it strips the sync word, parses the 32-bit packet header, then forwards exactly word-count payload bytes with per-byte keep and last flags. Beyond the fixed 2-lane decoder it adds short-packet reporting, a virtual-channel filter, early abort, and optional header ECC checking.

## Interface
- LANES, 2, number of byte lanes (legal values 1, 2, 4); data width is 8*LANES
- clk_i  in  1  byte clock; all logic is on the rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- data_valid_i  in  1  aligner burst valid; high from the sync word to the end of HS burst
- data_i  in  8*LANES  aligned lane bytes; lane0 is [7:0] and carries the earliest byte
- vc_mask_i  in  4  bit n set means virtual channel n is accepted; static while a packet is in flight
- output_valid_o  out  1  payload word valid
- data_o  out  8*LANES  payload bytes, same lane order as data_i
- keep_o  out  LANES  per-byte valid; all ones except possibly on the last word
- last_o  out  1  final payload word of the packet
- packet_type_o  out  6  header data type (DI[5:0])
- packet_vc_o  out  2  header virtual channel (DI[7:6])
- packet_length_o  out  16  header word count, or the short-packet data field
- short_valid_o  out  1  one-cycle pulse when an accepted short packet is decoded
- ecc_error_o  out  1  one-cycle pulse when a header ECC mismatch is detected

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, WAIT_END.
- Reset: the FSM goes to IDLE. All outputs reset to 0: output_valid_o, data_o, keep_o, last_o, packet_type_o, packet_vc_o, packet_length_o, short_valid_o, ecc_error_o.
- IDLE → HEADER: data_valid_i=1 and every lane equals 0xB8.
  - If data_valid_i=1 but any lane is not 0xB8, go to WAIT_END.
- HEADER: collect header bytes DI, WC_L, WC_H, ECC in byte order (lane0 first, then the next word).
  - Takes 4/LANES valid words: 4 words at LANES=1, 2 at LANES=2, 1 at LANES=4.
- On the final header word:
  - Register packet_type_o, packet_vc_o and packet_length_o = {WC_H, WC_L}.
  - Load the remaining-byte counter (16 bit) with WC.
- Short packet (DT ≤ 0x0F):
  - If the VC is accepted, pulse short_valid_o.
  - Then go to WAIT_END.
- Long packet:
  - WC=0: go to WAIT_END with no payload output.
  - Otherwise go to PAYLOAD.
- PAYLOAD: each valid word decrements the counter by LANES.
  - output_valid_o = 1 only if vc_mask_i[packet_vc_o] is set; filtered packets are consumed silently.
  - When remaining ≤ LANES: assert last_o and set keep_o to the low `remaining` bits (e.g. remaining=1 at LANES=4 gives keep_o=4'b0001), then go to WAIT_END.
  - Bytes in lanes not covered by keep_o are don't-care.
- WAIT_END: ignore input until data_valid_i=0, then return to IDLE. Trailing CRC and filler bytes are discarded.
- Abort: data_valid_i=0 in HEADER or PAYLOAD returns the FSM to IDLE.
  - No last_o is emitted.
  - Header outputs keep their last values.
- data_valid_i=0 in any state returns to IDLE on the next edge.
- A new burst can start on the cycle after data_valid_i falls.

## Timing
- All outputs are registered.
- Header fields appear 1 cycle after the final header word.
- Payload output latency is 1 cycle: data_o at edge k+1 corresponds to data_i at edge k.
- short_valid_o and ecc_error_o are single-cycle pulses, issued 1 cycle after the final header word.
- output_valid_o has no gaps inside a packet unless data_valid_i drops (abort).
- Throughput: LANES bytes per clock with no back-pressure.
- Reset asserted mid-packet clears all outputs immediately (asynchronous). Decoding restarts only with a fresh sync word.

## Configuration
- MIPI_CSI_RX_ECC_CHECK_EN defined:
  - Compute the 6-bit CSI-2 header ECC over {WC_H, WC_L, DI} and compare it with ECC[5:0].
  - On mismatch: pulse ecc_error_o, suppress short_valid_o and all payload, go to WAIT_END. Header outputs still update.
  - No single-bit correction.
- Undefined:
  - The ECC byte is ignored.
  - ecc_error_o is tied to 0.

## Test plan
- LANES=2, vc_mask_i=4'hF, words B8B8, 062B, 0000, then three payload words 1111, 2222, 3333 → packet_type_o=0x2B, packet_length_o=6, three output words with last_o on 3333, keep_o=2'b11.
- LANES=4, WC=5, payload AAAAAAAA, 000000BB → second word has last_o=1 and keep_o=4'b0001. Further input words until data_valid_i falls produce no output.
- LANES=2, short packet DI=0x00, WC=0x0007 → short_valid_o pulses once with packet_length_o=7 and output_valid_o stays 0.
- Header DI=0x6B (VC1), vc_mask_i=4'b0001, WC=4 → packet_vc_o=1, no output_valid_o. The next VC0 packet is forwarded normally.
- data_valid_i drops after the first payload word of a WC=100 packet → FSM returns to IDLE with no last_o. The next burst B8B8 decodes correctly.
- With MIPI_CSI_RX_ECC_CHECK_EN defined, flip WC bit 0 of a valid header → ecc_error_o pulses 1 cycle and no payload is forwarded. Without the macro the same stimulus forwards the payload.
